// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_pkg
// Purpose  : Shared state encoding and configuration defaults for the detector.
// Revision : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] c_DEF_PATTERN = 16'h0000;
  localparam int unsigned c_DEF_LEN     = 1;
  localparam logic        c_DEF_OVERLAP = 1'b1;

endpackage
`default_nettype wire

// File: rtl/seq_match_core.sv
`default_nettype none
// ============================================================================
// Module   : seq_match_core
// Purpose  : Shift history, fill tracking and Mealy pattern compare.
// Revision : 1.0 - initial release
// ============================================================================
module seq_match_core #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             en,
  input  logic             clr,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             y
);

  localparam int c_FILL_W = $clog2(PAT_W + 1);
  localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(PAT_W);
  localparam logic [c_FILL_W-1:0] c_FILL_ONE = c_FILL_W'(1);

  logic [PAT_W-2:0]    r_hist;
  logic [c_FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]    w_cand;
  logic [PAT_W-1:0]    w_mask;
  logic                w_enough;

  assign w_cand = {r_hist, din};

  // Only the low len bits of the candidate window take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(len));
    end
  end

  assign w_enough = (int'(r_fill) + 1) >= int'(len);
  assign y = en & din_valid & w_enough & (((w_cand ^ pattern) & w_mask) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (en && din_valid) begin
      r_hist <= w_cand[PAT_W-2:0];
      if (y && !overlap) begin
        r_fill <= '0;
      end else if (r_fill != c_FILL_MAX) begin
        r_fill <= r_fill + c_FILL_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_ctrl
// Purpose  : Configurable serial sequence-detection controller with match
//            counting, threshold interrupt and optional timeout
//            (SEQ_DETECT_CTRL_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8,
  parameter int TMO_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             start,
  input  logic             stop,
  input  logic             din,
  input  logic             din_valid,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             irq,
  output logic             busy,
  output logic             err,
  output logic             timeout
);

  localparam logic [1:0] c_S_IDLE = IDLE;
  localparam logic [1:0] c_S_RUN  = RUN;
  localparam logic [1:0] c_S_DONE = DONE;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [1:0]       r_state;
  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic             r_overlap;
  logic [CNT_W-1:0] r_thresh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_irq;
  logic             r_err;

  logic w_run;
  logic w_y;
  logic w_len_ok;
  logic w_start_ok;
  logic w_start_bad;
  logic w_thr_hit;
  logic w_tmo_hit;

  assign w_run       = (r_state == c_S_RUN);
  assign w_len_ok    = (r_len != '0) && (int'(r_len) <= PAT_W);
  assign w_start_ok  = start & ~stop & ~w_run & w_len_ok;
  assign w_start_bad = start & ~stop & ~w_run & ~w_len_ok;
  assign w_thr_hit   = w_y & (r_thresh != '0) & ((r_cnt + c_CNT_ONE) == r_thresh);

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .en        (w_run),
    .clr       (w_start_ok),
    .len       (r_len),
    .pattern   (r_pattern),
    .overlap   (r_overlap),
    .y         (w_y)
  );

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  localparam logic [TMO_W-1:0] c_TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] c_TMO_ONE  = TMO_W'(1);

  logic [TMO_W-1:0] r_tmo;
  logic             r_timeout;

  // Fires on the valid non-matching bit that brings the counter to all-ones.
  assign w_tmo_hit = w_run & din_valid & ~w_y & (r_tmo == c_TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_tmo <= '0;
      end else if (w_run && din_valid) begin
        r_tmo <= w_y ? '0 : (r_tmo + c_TMO_ONE);
      end
      if (w_start_ok) begin
        r_timeout <= 1'b0;
      end else if (w_tmo_hit && !stop) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  logic [TMO_W-1:0] w_tmo_unused;
  assign w_tmo_unused = '0;
  assign w_tmo_hit    = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_S_IDLE;
      r_pattern <= c_DEF_PATTERN[PAT_W-1:0];
      r_len     <= LEN_W'(c_DEF_LEN);
      r_overlap <= c_DEF_OVERLAP;
      r_thresh  <= '0;
      r_cnt     <= '0;
      r_irq     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      r_err <= w_start_bad;
      case (r_state)
        c_S_IDLE, c_S_DONE: begin
          if (stop) begin
            r_state <= c_S_IDLE;
          end else if (w_start_ok) begin
            r_state <= c_S_RUN;
          end
        end
        c_S_RUN: begin
          if (stop) begin
            r_state <= c_S_IDLE;
          end else if (w_thr_hit || w_tmo_hit) begin
            r_state <= c_S_DONE;
            r_irq   <= 1'b1;
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
      if (w_start_ok) begin
        r_cnt <= '0;
      end else if (w_y && (r_cnt != '1)) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
      if (cfg_we && !w_run) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_thresh  <= cfg_thresh;
      end
    end
  end

  assign y         = w_y;
  assign match_cnt = r_cnt;
  assign irq       = r_irq;
  assign busy      = w_run;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_ctrl
// Purpose  : Scoreboard bench for seq_detect_ctrl against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;
  localparam int TMO_W = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_thresh = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             irq;
  logic             busy;
  logic             err;
  logic             timeout;

  seq_detect_ctrl #(
    .PAT_W (PAT_W), .LEN_W (LEN_W), .CNT_W (CNT_W), .TMO_W (TMO_W)
  ) dut (
    .clk (clk), .rst (rst), .cfg_we (cfg_we), .cfg_pattern (cfg_pattern),
    .cfg_len (cfg_len), .cfg_overlap (cfg_overlap), .cfg_thresh (cfg_thresh),
    .start (start), .stop (stop), .din (din), .din_valid (din_valid),
    .y (y), .match_cnt (match_cnt), .irq (irq), .busy (busy), .err (err),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       y;
    logic [7:0] cnt;
    logic       busy;
    logic       irq;
    logic       err;
    logic       tmo;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;

  // Behavioural model: received bits kept as a plain queue.
  int         m_mode = 0;   // 0 idle, 1 running, 2 done
  bit         m_bits[$];
  int         m_cnt = 0;
  bit         m_irq = 0;
  bit         m_err = 0;
  logic [7:0] m_pat = '0;
  int         m_len = 1;
  bit         m_ovl = 1;
  int         m_thr = 0;

  logic [7:0] g_pat = '0;
  logic [3:0] g_len = 4'd1;
  bit         g_ovl = 1;
  logic [7:0] g_thr = '0;

  function automatic bit model_match(bit d);
    int n;
    n = m_bits.size();
    if (n + 1 < m_len) return 1'b0;
    if (d != m_pat[0]) return 1'b0;
    for (int k = 1; k < m_len; k++) begin
      if (m_bits[n-k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic cycle(input bit r, input bit we, input bit st, input bit sp,
                       input bit d, input bit dv);
    exp_t e;
    bit   yy, hit, irq_n, err_n;
    @(posedge clk);
    #1;
    rst = r; cfg_we = we; cfg_pattern = g_pat; cfg_len = g_len;
    cfg_overlap = g_ovl; cfg_thresh = g_thr; start = st; stop = sp;
    din = d; din_valid = dv;
    if (r) begin
      m_mode = 0; m_bits.delete(); m_cnt = 0; m_irq = 0; m_err = 0;
      m_pat = '0; m_len = 1; m_ovl = 1; m_thr = 0;
      e = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      sb_q.push_back(e);
    end else begin
      yy = (m_mode == 1) && dv && model_match(d);
      e = '{yy, 8'(m_cnt), (m_mode == 1), m_irq, m_err, 1'b0};
      sb_q.push_back(e);
      irq_n = 0; err_n = 0;
      if (m_mode == 1) begin
        hit = yy && (m_thr != 0) && (m_cnt + 1 == m_thr);
        if (yy && m_cnt < 255) m_cnt++;
        if (dv) begin
          m_bits.push_back(d);
          if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
          if (yy && !m_ovl) m_bits.delete();
        end
        if (sp) m_mode = 0;
        else if (hit) begin m_mode = 2; irq_n = 1; end
      end else begin
        if (sp) m_mode = 0;
        else if (st) begin
          if (m_len >= 1 && m_len <= PAT_W) begin
            m_mode = 1; m_bits.delete(); m_cnt = 0;
          end else err_n = 1;
        end
        if (we) begin
          m_pat = g_pat; m_len = int'(g_len); m_ovl = g_ovl; m_thr = int'(g_thr);
        end
      end
      m_irq = irq_n; m_err = err_n;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input bit o,
                     input logic [7:0] t);
    g_pat = p; g_len = l; g_ovl = o; g_thr = t;
    cycle(0, 1, 0, 0, 0, 0);
  endtask

  task automatic stream(input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) cycle(0, 0, 0, 0, v[i], 1);
  endtask

  // Monitor: one expected record per cycle, checked away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (y !== e.y || match_cnt !== e.cnt || busy !== e.busy ||
            irq !== e.irq || err !== e.err || timeout !== e.tmo) begin
          n_mis++;
          $display("FAIL outputs cyc=%0d got y=%b cnt=%0d busy=%b irq=%b err=%b tmo=%b required y=%b cnt=%0d busy=%b irq=%b err=%b tmo=%b",
                   cyc, y, match_cnt, busy, irq, err, timeout,
                   e.y, e.cnt, e.busy, e.irq, e.err, e.tmo);
        end
      end
    end
  end

  initial begin
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    idle(2);

    // 11001 overlapping, then non-overlapping
    cfg(8'b0001_1001, 4'd5, 1, 8'd0);
    cycle(0, 0, 1, 0, 0, 0);
    stream(16'b0110011001, 10);
    idle(2);
    cycle(0, 0, 0, 1, 0, 0);
    cfg(8'b0001_1001, 4'd5, 0, 8'd0);
    cycle(0, 0, 1, 0, 0, 0);
    stream(16'b0110011001, 10);
    cycle(0, 0, 0, 1, 0, 0);

    // threshold 3 on pattern 10, then bits after DONE
    cfg(8'b10, 4'd2, 1, 8'd3);
    cycle(0, 0, 1, 0, 0, 0);
    stream(16'b10101010, 8);
    idle(2);

    // illegal lengths
    cfg(8'b10, 4'd0, 1, 8'd0);
    cycle(0, 0, 1, 0, 0, 0);
    idle(1);
    cfg(8'b10, 4'd9, 1, 8'd0);
    cycle(0, 0, 1, 0, 0, 0);
    idle(1);

    // config write during RUN is ignored
    cfg(8'b011, 4'd3, 1, 8'd0);
    cycle(0, 0, 1, 0, 0, 0);
    cfg(8'b101, 4'd3, 1, 8'd0);
    stream(16'b0110110, 7);

    // async reset mid-RUN with count 2
    cycle(1, 0, 0, 0, 0, 0);
    idle(1);

    // start and stop together, then stop on a matching bit
    cfg(8'b1, 4'd1, 1, 8'd0);
    cycle(0, 0, 1, 1, 0, 0);
    idle(1);
    cycle(0, 0, 1, 0, 0, 0);
    stream(16'b101, 3);
    cycle(0, 0, 0, 1, 1, 1);
    idle(2);

    // back-to-back matches into counter saturation
    cycle(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 262; i++) cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 0, 0);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, we, st, sp, d, dv;
      r  = ($urandom_range(0, 399) == 0);
      we = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 24) == 0);
      d  = 1'($urandom);
      dv = ($urandom_range(0, 3) != 0);
      if (we) begin
        g_pat = 8'($urandom);
        g_len = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                            : 4'($urandom_range(1, 4));
        g_ovl = 1'($urandom);
        g_thr = 8'($urandom_range(0, 5));
      end
      cycle(r, we, st, sp, d, dv);
    end

    idle(2);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain got %0d pending required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
